// File: rtl/if_id_buffer_pkg.sv
// Shared constants for the IF/ID instruction queue: bus-width defaults, the zero word
// and the enable/stop level encodings used on the fetch/decode boundary.
package if_id_buffer_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned INST_W_DEF = 32;

    localparam logic [INST_W_DEF-1:0] ZERO_WORD = '0;

    localparam logic EN     = 1'b1;
    localparam logic DIS    = 1'b0;
    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

endpackage

// File: rtl/if_id_buffer.sv
// DEPTH-entry IF/ID instruction queue with flush; an empty queue shows a zero bubble to ID.
// Optional macro IF_ID_BYPASS_EN adds a zero-latency path from IF to ID when the queue is empty.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned INST_W = INST_W_DEF,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       if_valid_i,
    input  logic [ADDR_W-1:0]          if_pc_i,
    input  logic [INST_W-1:0]          if_inst_i,
    output logic                       if_ready_o,
    input  logic                       stall_i,
    output logic                       id_valid_o,
    output logic [ADDR_W-1:0]          id_pc_o,
    output logic [INST_W-1:0]          id_inst_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic empty;
    logic push;
    logic pop;
    logic bypass;
    logic wr_en;
    logic rd_en;

    assign empty      = (count_q == '0);
    assign if_ready_o = (count_q != CntW'(DEPTH)) ? EN : DIS;
    assign push       = if_valid_i && if_ready_o;
    assign pop        = id_valid_o && (stall_i == NOSTOP);

`ifdef IF_ID_BYPASS_EN
    assign bypass = empty && if_valid_i && (stall_i == NOSTOP) && !flush_i;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry is consumed straight from IF, so it never touches storage.
    assign wr_en = push && !bypass && !flush_i;
    assign rd_en = pop && !bypass && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(wr_en) - CntW'(rd_en);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible while count is zero.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr_q]   <= if_pc_i;
            inst_mem[wr_ptr_q] <= if_inst_i;
        end
    end

    always_comb begin
        id_valid_o = !empty;
        id_pc_o    = '0;
        id_inst_o  = ZERO_WORD[INST_W-1:0];
        if (!empty) begin
            id_pc_o   = pc_mem[rd_ptr_q];
            id_inst_o = inst_mem[rd_ptr_q];
        end else if (bypass) begin
            id_valid_o = 1'b1;
            id_pc_o    = if_pc_i;
            id_inst_o  = if_inst_i;
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: stimulus queues expected {pc, inst} pairs, a negedge
// monitor pops and compares them whenever ID consumes an entry.
module tb_if_id_buffer;

    localparam int unsigned DEPTH = 4;
`ifdef IF_ID_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [2:0]  count;

    int vectors    = 0;
    int miscompares = 0;
    int mcnt       = 0;
    logic [63:0] sbq[$];

    if_id_buffer #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .if_valid_i (if_valid),
        .if_pc_i    (if_pc),
        .if_inst_i  (if_inst),
        .if_ready_o (if_ready),
        .stall_i    (stall),
        .id_valid_o (id_valid),
        .id_pc_o    (id_pc),
        .id_inst_o  (id_inst),
        .count_o    (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hdead_beef;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the head against the scoreboard and retires it when ID consumes it.
    always @(negedge clk) begin
        if (!rst) begin
            if (id_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_valid", {31'b0, id_valid}, 32'h0);
                end else begin
                    check("head_pc", id_pc, sbq[0][63:32]);
                    check("head_inst", id_inst, sbq[0][31:0]);
                    if (!stall) void'(sbq.pop_front());
                end
            end else begin
                check("bubble_pc", id_pc, 32'h0);
                check("bubble_inst", id_inst, 32'h0);
            end
        end
    end

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic st, input logic fl);
        bit acc;
        bit byp;
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst_of(pc);
        stall    = st;
        flush    = fl;
        acc = v && (mcnt != DEPTH);
        byp = BYP && (mcnt == 0) && v && !st && !fl;
        if (acc && !fl) sbq.push_back({pc, inst_of(pc)});
        @(negedge clk);
        check("count", 32'(count), 32'(mcnt));
        check("if_ready", {31'b0, if_ready}, {31'b0, mcnt != DEPTH});
        check("id_valid", {31'b0, id_valid}, {31'b0, (mcnt != 0) || byp});
        @(posedge clk);
        #1;
        if (fl) begin
            mcnt = 0;
            sbq.delete();
        end else begin
            mcnt = mcnt + int'(acc && !byp) - int'(!st && mcnt != 0);
        end
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) idle();
        check("drained_valid", {31'b0, id_valid}, 32'h0);
        check("drained_pc", id_pc, 32'h0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; stall = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'h0);
        check("rst_valid", {31'b0, id_valid}, 32'h0);
        check("rst_pc", id_pc, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'b0, if_ready}, 32'h1);

        // Three stalled pushes, then release in order.
        cyc(1'b1, 32'h100, 1'b1, 1'b0);
        check("first_latency_pc", id_pc, 32'h100);
        cyc(1'b1, 32'h104, 1'b1, 1'b0);
        cyc(1'b1, 32'h108, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("stalled_count", 32'(count), 32'h3);
        check("stalled_head", id_pc, 32'h100);
        drain();

        // Fill to DEPTH; the fifth offer waits at IF until a pop frees a slot.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'h180 + 32'(4 * i), 1'b1, 1'b0);
        check("full_count", 32'(count), 32'h4);
        check("full_ready", {31'b0, if_ready}, 32'h0);
        cyc(1'b1, 32'h200, 1'b1, 1'b0);
        cyc(1'b1, 32'h200, 1'b0, 1'b0);
        check("after_pop_count", 32'(count), 32'h3);
        cyc(1'b1, 32'h200, 1'b1, 1'b0);
        check("refill_count", 32'(count), 32'h4);
        drain();

        // Steady push+pop at occupancy 2 across pointer wrap.
        cyc(1'b1, 32'h500, 1'b1, 1'b0);
        cyc(1'b1, 32'h504, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'h508 + 32'(4 * i), 1'b0, 1'b0);
            check("steady_count", 32'(count), 32'h2);
        end
        drain();

        // Flush with three entries while 0x300 is offered.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h280 + 32'(4 * i), 1'b1, 1'b0);
        cyc(1'b1, 32'h300, 1'b1, 1'b1);
        check("flush_count", 32'(count), 32'h0);
        check("flush_valid", {31'b0, id_valid}, 32'h0);
        drain();

        // Asynchronous reset between edges with two entries held.
        cyc(1'b1, 32'h600, 1'b1, 1'b0);
        cyc(1'b1, 32'h604, 1'b1, 1'b0);
        if_valid = 1'b0; stall = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_count", 32'(count), 32'h0);
        check("async_rst_valid", {31'b0, id_valid}, 32'h0);
        check("async_rst_pc", id_pc, 32'h0);
        rst = 1'b0;
        mcnt = 0;
        sbq.delete();
        @(posedge clk); #1;
        cyc(1'b1, 32'h700, 1'b1, 1'b0);
        check("post_rst_alone_count", 32'(count), 32'h1);
        check("post_rst_alone_pc", id_pc, 32'h700);
        drain();

`ifdef IF_ID_BYPASS_EN
        cyc(1'b1, 32'h400, 1'b0, 1'b0);
        check("bypass_count", 32'(count), 32'h0);
        cyc(1'b1, 32'h404, 1'b1, 1'b0);
        check("bypass_stalled_count", 32'(count), 32'h1);
        drain();
`endif

        if (sbq.size() != 0) check("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Parametrised successor to the single-entry IF/ID pipeline latch: a DEPTH-entry instruction queue between fetch and decode.
- IF pushes {pc, inst} pairs with a valid/ready handshake; ID consumes the head entry unless stalled.
- A flush empties the queue on branch redirect or exception.
- An empty queue presents a zero bubble to ID, the same as the old latch's stall-insert behaviour.

Parameters:
- ADDR_W, 32, PC width.
- INST_W, 32, instruction width.
- DEPTH, 4, number of entries; power of two, minimum 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush_i  in  1  synchronous queue clear.
- if_valid_i  in  1  IF offers an entry.
- if_pc_i  in  ADDR_W  PC of the offered entry.
- if_inst_i  in  INST_W  instruction of the offered entry.
- if_ready_o  out  1  queue accepts an entry this cycle.
- stall_i  in  1  ID stalled; head is not consumed.
- id_valid_o  out  1  head entry is valid.
- id_pc_o  out  ADDR_W  head PC, zero when invalid.
- id_inst_o  out  INST_W  head instruction, zero when invalid.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset: pointers, count_o, id_valid_o, id_pc_o and id_inst_o go to 0 immediately on assertion. Storage contents are don't-care. if_ready_o=1 once rst deasserts.
- push = if_valid_i && if_ready_o.
- pop = id_valid_o && !stall_i.
- if_ready_o = (count != DEPTH). It depends on registered state only, with no combinational path from stall_i or if_valid_i.
  - When full, push is refused even if a pop happens in the same cycle.
- id_valid_o = (count != 0).
- id_pc_o/id_inst_o = head entry when valid, else all zeros. Both are driven from flops through a mux.
- Latency: an entry pushed in cycle N is visible on id_* in cycle N+1 if the queue was empty.
- Order is strict FIFO.
- Push and pop in the same cycle: count is unchanged, write pointer and read pointer both advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count is tracked separately, so full and empty are never ambiguous.
- flush_i has priority over push and pop in the same cycle:
  - Pointers and count clear at the next edge.
  - A simultaneous push is dropped.
  - id_valid_o=0 from the next cycle.
- flush_i while stall_i=1 still clears the queue.
- rst asserted mid-operation: every entry is discarded asynchronously, with no partial-state survival.
- When stall_i=1 and the queue is empty, the outputs stay at the zero bubble.

Optional Feature:
- Macro: IF_ID_BYPASS_EN.
- With the macro defined: when count==0, if_valid_i=1, stall_i=0 and flush_i=0:
  - id_valid_o, id_pc_o and id_inst_o are driven combinationally from the if_* inputs.
  - The entry is consumed in that same cycle and not written into storage, giving zero latency.
  - In every other case behaviour is identical to the macro-off case.
- Without the macro: no combinational input-to-output path, and the minimum latency is 1 cycle.

Decomposition:
- The shared defines/package holds:
  - the zero-word constant;
  - instruction and address bus widths used as parameter defaults;
  - the enable/disable and stop/not-stop level constants.
- The existing stall-bus bit is mapped to stall_i outside this block.
- No sub-module. Storage, pointers and count fit in one module of roughly 150–250 lines.

Test Plan:
- Reset, then 3 pushes (pc 0x100/0x104/0x108) with stall_i=1 → count_o=3, id_pc_o=0x100; release stall → 0x100, 0x104, 0x108 on consecutive cycles, then id_valid_o=0 with zero outputs.
- Fill DEPTH=4 with stall_i=1 → if_ready_o=0 at count 4; a fifth offer (pc 0x200) is not accepted and stays at IF until a pop frees space.
- Continuous push and pop at count 2 for 10 cycles → count_o holds at 2; PCs emerge in order across the pointer wrap.
- flush_i asserted with count=3 while pushing 0x300 → next cycle count_o=0, id_valid_o=0, and 0x300 never appears at ID.
- rst pulsed asynchronously between edges with count=2 → outputs zero before the next edge; the first post-reset push appears alone.
- IF_ID_BYPASS_EN defined, empty, push 0x400 with stall_i=0 → id_pc_o=0x400 in the same cycle and count_o stays 0; repeat with stall_i=1 → the entry is stored and count_o=1.
